// File: rtl/lane_dist_ctrl_if.sv
// Control bundle between the lane scheduler and its requesters / distributer.
// master: ordered-set generator, transport path and link monitor side.
// slave : the scheduler (lane_dist_ctrl).
interface lane_dist_ctrl_if #(
   parameter int LEN_W = 8
);
   logic             link_up;
   logic             os_req;
   logic [3:0]       os_sel;
   logic [LEN_W-1:0] os_len;
   logic             os_gnt;
   logic             os_done;
   logic             os_abort;
   logic             os_err;
   logic             tl_req;
   logic             tl_gnt;
   logic [3:0]       d_sel;
   logic             enable_t;
   logic             enable_r;
   logic             busy;

   modport master (
      output link_up, os_req, os_sel, os_len, tl_req,
      input  os_gnt, os_done, os_abort, os_err, tl_gnt,
      input  d_sel, enable_t, enable_r, busy
   );

   modport slave (
      input  link_up, os_req, os_sel, os_len, tl_req,
      output os_gnt, os_done, os_abort, os_err, tl_gnt,
      output d_sel, enable_t, enable_r, busy
   );
endinterface

// File: rtl/lane_dist_ctrl.sv
// Lane distributer scheduler: shares the transmit lanes between the
// ordered-set generator and the transport data path, drains the tx pipeline
// between owners and gates the receive side on link state.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | lanes released, enable_t=0; arbitrates os_req / tl_req
// S_OS   | ordered set on the lanes for its latched length
// S_TL   | transport data on the lanes (d_sel=8)
// S_GAP  | tx pipeline drain, enable_t held, d_sel frozen, no grants
module lane_dist_ctrl #(
   parameter int LEN_W        = 8,
   parameter int GAP_CYCLES   = 2,
   parameter int TL_MAX_BURST = 64
) (
   input logic             clk,
   input logic             rst,
   lane_dist_ctrl_if.slave bus
);
   localparam int                 BURST_W    = $clog2(TL_MAX_BURST) + 1;
   localparam logic [3:0]         SEL_TL     = 4'h8;
   localparam logic [3:0]         GAP_LOAD   = 4'(GAP_CYCLES - 1);
   localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(TL_MAX_BURST - 1);
   localparam logic [BURST_W-1:0] BURST_SAT  = '1;

   typedef enum logic [1:0] {S_IDLE, S_OS, S_TL, S_GAP} state_t;

   state_t             state;
   logic               last_os;
   logic [LEN_W-1:0]   len_cnt;
   logic [BURST_W-1:0] burst_cnt;
   logic [3:0]         gap_cnt;

   logic [3:0] d_sel_q;
   logic       enable_t_q, enable_r_q, tl_gnt_q, busy_q;
   logic       os_gnt_q, os_done_q, os_abort_q, os_err_q;

   logic             os_valid;
   logic             os_bad;
   logic             os_wins;
   logic [LEN_W-1:0] len_load;

   // Request qualification and round-robin pick; len_load is remaining cycles after the first.
   always_comb begin
      os_valid = bus.os_req && (bus.os_sel != SEL_TL);
      os_bad   = bus.os_req && (bus.os_sel == SEL_TL);
      os_wins  = os_valid && !(bus.tl_req && last_os);
      len_load = (bus.os_len == '0) ? '0 : bus.os_len - LEN_W'(1);
   end

   // Scheduler FSM with all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         last_os    <= 1'b1;
         len_cnt    <= '0;
         burst_cnt  <= '0;
         gap_cnt    <= '0;
         d_sel_q    <= '0;
         enable_t_q <= 1'b0;
         enable_r_q <= 1'b0;
         tl_gnt_q   <= 1'b0;
         busy_q     <= 1'b0;
         os_gnt_q   <= 1'b0;
         os_done_q  <= 1'b0;
         os_abort_q <= 1'b0;
         os_err_q   <= 1'b0;
      end else begin
         enable_r_q <= bus.link_up;
         os_gnt_q   <= 1'b0;
         os_done_q  <= 1'b0;
         os_abort_q <= 1'b0;
         os_err_q   <= 1'b0;
         if (!bus.link_up) begin
            // link loss skips the drain gap: lanes are dead anyway
            os_abort_q <= (state == S_OS);
            state      <= S_IDLE;
            enable_t_q <= 1'b0;
            tl_gnt_q   <= 1'b0;
            d_sel_q    <= '0;
            busy_q     <= 1'b0;
            len_cnt    <= '0;
            burst_cnt  <= '0;
            gap_cnt    <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  os_err_q <= os_bad;
                  if (os_wins) begin
                     state      <= S_OS;
                     d_sel_q    <= bus.os_sel;
                     enable_t_q <= 1'b1;
                     busy_q     <= 1'b1;
                     os_gnt_q   <= 1'b1;
                     last_os    <= 1'b1;
                     len_cnt    <= len_load;
                     os_done_q  <= (len_load == '0);
                  end else if (bus.tl_req) begin
                     state      <= S_TL;
                     d_sel_q    <= SEL_TL;
                     enable_t_q <= 1'b1;
                     tl_gnt_q   <= 1'b1;
                     busy_q     <= 1'b1;
                     last_os    <= 1'b0;
                     burst_cnt  <= '0;
                  end
               end
               S_OS: begin
                  if (len_cnt == '0) begin
                     state   <= S_GAP;
                     gap_cnt <= GAP_LOAD;
                  end else begin
                     len_cnt   <= len_cnt - LEN_W'(1);
                     os_done_q <= (len_cnt == LEN_W'(1));
                  end
               end
               S_TL: begin
                  // >= rather than == so an OS request arriving after saturation still preempts
                  if (!bus.tl_req || (os_valid && (burst_cnt >= BURST_LAST))) begin
                     state    <= S_GAP;
                     tl_gnt_q <= 1'b0;
                     gap_cnt  <= GAP_LOAD;
                  end else if (burst_cnt != BURST_SAT) begin
                     burst_cnt <= burst_cnt + BURST_W'(1);
                  end
               end
               S_GAP: begin
                  if (gap_cnt == '0) begin
                     state      <= S_IDLE;
                     enable_t_q <= 1'b0;
                     d_sel_q    <= '0;
                     busy_q     <= 1'b0;
                  end else begin
                     gap_cnt <= gap_cnt - 4'd1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.d_sel    = d_sel_q;
   assign bus.enable_t = enable_t_q;
   assign bus.enable_r = enable_r_q;
   assign bus.tl_gnt   = tl_gnt_q;
   assign bus.busy     = busy_q;
   assign bus.os_gnt   = os_gnt_q;
   assign bus.os_done  = os_done_q;
   assign bus.os_abort = os_abort_q;
   assign bus.os_err   = os_err_q;
endmodule

// File: tb/tb_lane_dist_ctrl.sv
// Bench for lane_dist_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle to an ownership model.
module tb_lane_dist_ctrl;
   localparam int LEN_W = 8;
   localparam int GAP   = 2;
   localparam int MAXB  = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   lane_dist_ctrl_if #(.LEN_W(LEN_W)) bus ();

   lane_dist_ctrl #(
      .LEN_W(LEN_W),
      .GAP_CYCLES(GAP),
      .TL_MAX_BURST(MAXB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Ownership model: who holds the lanes and for how many cycles so far.
   typedef enum int {PH_IDLE, PH_OS, PH_TL, PH_GAP} phase_t;
   phase_t     ph;
   int         el;
   int         os_len_m;
   logic [3:0] os_code;
   logic [3:0] gap_code;
   bit         last_was_os;
   bit         x_gnt, x_abort, x_err, x_enr;

   task automatic chk(string name, int got, int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
      end
   endtask

   task automatic model_reset();
      ph = PH_IDLE; el = 0; os_len_m = 1; os_code = 0; gap_code = 0;
      last_was_os = 1; x_gnt = 0; x_abort = 0; x_err = 0; x_enr = 0;
   endtask

   task automatic model_step();
      bit os_ok, os_bad;
      if (rst) begin
         model_reset();
         return;
      end
      x_gnt = 0; x_abort = 0; x_err = 0;
      x_enr  = bus.link_up;
      os_ok  = bus.os_req && (bus.os_sel != 4'h8);
      os_bad = bus.os_req && (bus.os_sel == 4'h8);
      if (!bus.link_up) begin
         x_abort = (ph == PH_OS);
         ph = PH_IDLE; el = 0;
      end else begin
         case (ph)
            PH_IDLE: begin
               x_err = os_bad;
               if (os_ok && !(bus.tl_req && last_was_os)) begin
                  ph = PH_OS; el = 1; os_code = bus.os_sel;
                  os_len_m = (bus.os_len == 0) ? 1 : int'(bus.os_len);
                  last_was_os = 1; x_gnt = 1;
               end else if (bus.tl_req) begin
                  ph = PH_TL; el = 1; last_was_os = 0;
               end
            end
            PH_OS: if (el >= os_len_m) begin ph = PH_GAP; el = 1; gap_code = os_code; end else el++;
            PH_TL: if (!bus.tl_req || (os_ok && el >= MAXB)) begin ph = PH_GAP; el = 1; gap_code = 4'h8; end else el++;
            PH_GAP: if (el >= GAP) begin ph = PH_IDLE; el = 0; end else el++;
            default: ph = PH_IDLE;
         endcase
      end
   endtask

   task automatic compare();
      logic [3:0] e_dsel;
      case (ph)
         PH_IDLE: e_dsel = 4'h0;
         PH_OS:   e_dsel = os_code;
         PH_TL:   e_dsel = 4'h8;
         default: e_dsel = gap_code;
      endcase
      chk("d_sel", int'(bus.d_sel), int'(e_dsel));
      chk("enable_t", bus.enable_t, int'(ph != PH_IDLE));
      chk("tl_gnt", bus.tl_gnt, int'(ph == PH_TL));
      chk("busy", bus.busy, int'(ph != PH_IDLE));
      chk("enable_r", bus.enable_r, x_enr);
      chk("os_gnt", bus.os_gnt, x_gnt);
      chk("os_done", bus.os_done, int'(ph == PH_OS && el == os_len_m));
      chk("os_abort", bus.os_abort, x_abort);
      chk("os_err", bus.os_err, x_err);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic idle_wait();
      for (int i = 0; i < 300 && bus.busy; i++) cyc();
      chk("idle_reached", bus.busy, 0);
   endtask

   initial begin
      int n_en, n_tl, n_err, n_gnt, n_done, done_at, k, got;
      int d7, d8;

      bus.link_up = 1; bus.os_req = 0; bus.os_sel = 0; bus.os_len = 0; bus.tl_req = 0;
      rst = 1;
      model_reset();
      repeat (2) @(negedge clk);
      compare();
      rst = 0;

      // T1: basic ordered set, len 5
      bus.os_req = 1; bus.os_sel = 4'h3; bus.os_len = 5;
      cyc();
      chk("t1_gnt", bus.os_gnt, 1);
      chk("t1_dsel", bus.d_sel, 3);
      bus.os_req = 0;
      n_en = 1; done_at = 0; d7 = -1; d8 = -1;
      for (int i = 2; i <= 10; i++) begin
         if (i == 3) bus.os_len = 8'd77;
         cyc();
         if (bus.enable_t) n_en++;
         if (bus.os_done) done_at = i;
         if (i == 7) d7 = bus.d_sel;
         if (i == 8) d8 = bus.d_sel;
      end
      chk("t1_en_cycles", n_en, 7);
      chk("t1_done_cycle", done_at, 5);
      chk("t1_gap_dsel", d7, 3);
      chk("t1_idle_dsel", d8, 0);

      // T2: zero length behaves as one
      bus.os_req = 1; bus.os_sel = 4'h5; bus.os_len = 0;
      cyc();
      chk("t2_gnt_done", {bus.os_gnt, bus.os_done}, 3);
      bus.os_req = 0;
      cyc();
      chk("t2_gap_no_done", {bus.enable_t, bus.os_done}, 2);
      idle_wait();

      // T3: long transport burst preempted by ordered set after MAXB cycles
      bus.tl_req = 1;
      cyc();
      chk("t3_tl_gnt", bus.tl_gnt, 1);
      n_tl = 1;
      for (int i = 0; i < 200; i++) begin
         if (n_tl == 10 && !bus.os_req) begin
            bus.os_req = 1; bus.os_sel = 4'h6; bus.os_len = 3;
         end
         cyc();
         if (!bus.tl_gnt) break;
         n_tl++;
      end
      chk("t3_tl_len", n_tl, 64);
      k = 0; got = 0;
      for (int i = 0; i < 20 && !got; i++) begin cyc(); k++; got = bus.os_gnt; end
      chk("t3_gap_to_gnt", k, 3);
      bus.os_req = 0;
      k = 0; got = 0;
      for (int i = 0; i < 20 && !got; i++) begin cyc(); k++; got = bus.tl_gnt; end
      chk("t3_tl_again", k, 6);
      bus.tl_req = 0;
      idle_wait();

      // T4: async reset mid ordered set, then round-robin from reset
      bus.os_req = 1; bus.os_sel = 4'h2; bus.os_len = 6;
      cyc();
      bus.os_req = 0;
      cyc();
      cyc();
      @(posedge clk);
      model_step();
      #2 rst = 1;
      #1 model_reset();
      chk("t4_rst_async", {bus.enable_t, bus.busy, bus.d_sel}, 0);
      @(negedge clk);
      compare();
      bus.os_req = 1; bus.os_sel = 4'h1; bus.os_len = 2; bus.tl_req = 1;
      rst = 0;
      cyc();
      chk("t4_first_tl", {bus.tl_gnt, bus.os_gnt}, 2);
      repeat (3) cyc();
      bus.tl_req = 0;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin cyc(); got = bus.os_gnt; end
      chk("t4_os_after_tl", got, 1);
      bus.os_req = 0;
      idle_wait();
      bus.os_req = 1; bus.tl_req = 1;
      cyc();
      chk("t4_second_tl", {bus.tl_gnt, bus.os_gnt}, 2);
      bus.tl_req = 0;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin cyc(); got = bus.os_gnt; end
      chk("t4_second_os", got, 1);
      bus.os_req = 0;
      idle_wait();

      // T5: illegal select is rejected every cycle
      bus.os_req = 1; bus.os_sel = 4'h8; bus.os_len = 4;
      n_err = 0; n_en = 0; n_gnt = 0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         n_err += int'(bus.os_err);
         n_en  += int'(bus.enable_t);
         n_gnt += int'(bus.os_gnt);
      end
      chk("t5_err_count", n_err, 5);
      chk("t5_no_enable", n_en, 0);
      chk("t5_no_gnt", n_gnt, 0);
      bus.tl_req = 1;
      cyc();
      chk("t5_tl_served", bus.tl_gnt, 1);
      bus.tl_req = 0; bus.os_req = 0;
      idle_wait();

      // T6: link loss during ordered set
      bus.os_req = 1; bus.os_sel = 4'hA; bus.os_len = 6;
      cyc();
      bus.os_req = 0;
      cyc();
      bus.link_up = 0;
      cyc();
      chk("t6_abort", bus.os_abort, 1);
      chk("t6_lanes_off", {bus.enable_t, bus.enable_r, bus.busy}, 0);
      n_done = 0; n_en = 0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         n_done += int'(bus.os_done);
         n_en   += int'(bus.enable_t);
      end
      chk("t6_no_done", n_done, 0);
      chk("t6_no_gap", n_en, 0);
      bus.link_up = 1;
      cyc();
      chk("t6_enr_back", bus.enable_r, 1);

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         if (bus.os_req) begin
            if (bus.os_gnt || (bus.os_sel == 4'h8 && $urandom_range(0, 3) == 0)) bus.os_req = 0;
         end else begin
            if ($urandom_range(0, 3) == 0) bus.os_len = LEN_W'($urandom_range(0, 9));
            if ($urandom_range(0, 9) == 0) begin
               bus.os_req = 1;
               bus.os_sel = ($urandom_range(0, 7) == 0) ? 4'h8 : 4'($urandom_range(0, 15));
               bus.os_len = LEN_W'($urandom_range(0, 6));
            end
         end
         if ($urandom_range(0, 39) == 0) bus.tl_req = ~bus.tl_req;
         if (bus.link_up) begin
            if ($urandom_range(0, 199) == 0) bus.link_up = 0;
         end else if ($urandom_range(0, 3) == 0) begin
            bus.link_up = 1;
         end
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
